bidir_switch_box: RTL and testbench

//  Bidirectional FPGA-style switch box with three routing tracks on each of the

---
 rtl/bidir_switch_box_pkg.sv | 30 +++
 rtl/bidir_switch_box_link.sv | 26 ++
 rtl/bidir_switch_box.sv | 74 +++++++
 tb/tb_bidir_switch_box.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bidir_switch_box_pkg.sv
// Shared definitions for the bidirectional switch box: track count, side-pair
// ordering and the configuration-bit map used by RTL and bench alike.
package bidir_switch_box_pkg;

  localparam int unsigned W      = 3;
  localparam int unsigned NUM_SP = 6;
  localparam int unsigned CFG_W  = 2 * NUM_SP * W;

  // Side pairs ordered (X,Y); the enum value is the pair index sp.
  typedef enum logic [2:0] {
    SP_LR = 3'd0,
    SP_BT = 3'd1,
    SP_LT = 3'd2,
    SP_LB = 3'd3,
    SP_RT = 3'd4,
    SP_RB = 3'd5
  } side_pair_e;

  localparam logic DIR_YX = 1'b0;
  localparam logic DIR_XY = 1'b1;

  function automatic int unsigned cfg_bit(side_pair_e sp, int unsigned t, logic dir);
    return (W * 32'(sp) + t) * 2 + 32'(dir);
  endfunction

  function automatic logic gt_one(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bidir_switch_box_link.sv
// W-bit pair of opposing tristate drivers between two sides, with a guard that
// disables both directions when both enables are set.
module bidir_link #(
  parameter int unsigned W = 3
) (
  inout  logic [W-1:0] x,
  inout  logic [W-1:0] y,
  input  logic [W-1:0] en_xy,
  input  logic [W-1:0] en_yx
);

  logic [W-1:0] drv_xy;
  logic [W-1:0] drv_yx;

  // Both directions on at once would form a latch loop, so neither drives.
  always_comb begin
    drv_xy = en_xy & ~en_yx;
    drv_yx = en_yx & ~en_xy;
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign y[i] = drv_xy[i] ? x[i] : 1'bz;
    assign x[i] = drv_yx[i] ? y[i] : 1'bz;
  end

endmodule

// File: rtl/bidir_switch_box.sv
// Switch box top: registered routing configuration, six side-pair links and a
// registered illegal-configuration flag computed from the incoming word.
module bidir_switch_box #(
  parameter int unsigned W = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [12*W-1:0] cfg,
  inout  logic [W-1:0]  left,
  inout  logic [W-1:0]  right,
  inout  logic [W-1:0]  top,
  inout  logic [W-1:0]  bottom,
  output logic          cfg_err
);

  import bidir_switch_box_pkg::*;

  logic [12*W-1:0] cfg_d, cfg_q;
  logic            cfg_err_d, cfg_err_q;
  logic [W-1:0]    en_xy [NUM_SP];
  logic [W-1:0]    en_yx [NUM_SP];
  logic [W-1:0]    nx_xy [NUM_SP];
  logic [W-1:0]    nx_yx [NUM_SP];

  always_comb begin
    for (int unsigned sp = 0; sp < NUM_SP; sp++) begin
      en_xy[sp] = '0;
      en_yx[sp] = '0;
      nx_xy[sp] = '0;
      nx_yx[sp] = '0;
      for (int unsigned t = 0; t < W; t++) begin
        en_xy[sp][t] = cfg_q[cfg_bit(side_pair_e'(sp), t, DIR_XY)];
        en_yx[sp][t] = cfg_q[cfg_bit(side_pair_e'(sp), t, DIR_YX)];
        nx_xy[sp][t] = cfg[cfg_bit(side_pair_e'(sp), t, DIR_XY)];
        nx_yx[sp][t] = cfg[cfg_bit(side_pair_e'(sp), t, DIR_YX)];
      end
    end
  end

  // Error is judged on the incoming word so it lands together with cfg_q.
  always_comb begin
    cfg_d     = cfg;
    cfg_err_d = 1'b0;
    for (int unsigned t = 0; t < W; t++) begin
      for (int unsigned sp = 0; sp < NUM_SP; sp++) begin
        if (nx_xy[sp][t] && nx_yx[sp][t]) cfg_err_d = 1'b1;
      end
      if (gt_one(nx_yx[SP_LR][t], nx_yx[SP_LT][t], nx_yx[SP_LB][t])) cfg_err_d = 1'b1;
      if (gt_one(nx_xy[SP_LR][t], nx_yx[SP_RT][t], nx_yx[SP_RB][t])) cfg_err_d = 1'b1;
      if (gt_one(nx_xy[SP_BT][t], nx_xy[SP_LT][t], nx_xy[SP_RT][t])) cfg_err_d = 1'b1;
      if (gt_one(nx_yx[SP_BT][t], nx_xy[SP_LB][t], nx_xy[SP_RB][t])) cfg_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  bidir_link #(.W(W)) u_lr (.x(left),   .y(right),  .en_xy(en_xy[SP_LR]), .en_yx(en_yx[SP_LR]));
  bidir_link #(.W(W)) u_bt (.x(bottom), .y(top),    .en_xy(en_xy[SP_BT]), .en_yx(en_yx[SP_BT]));
  bidir_link #(.W(W)) u_lt (.x(left),   .y(top),    .en_xy(en_xy[SP_LT]), .en_yx(en_yx[SP_LT]));
  bidir_link #(.W(W)) u_lb (.x(left),   .y(bottom), .en_xy(en_xy[SP_LB]), .en_yx(en_yx[SP_LB]));
  bidir_link #(.W(W)) u_rt (.x(right),  .y(top),    .en_xy(en_xy[SP_RT]), .en_yx(en_yx[SP_RT]));
  bidir_link #(.W(W)) u_rb (.x(right),  .y(bottom), .en_xy(en_xy[SP_RB]), .en_yx(en_yx[SP_RB]));

endmodule

// File: tb/tb_bidir_switch_box.sv
// Directed bench for bidir_switch_box. Every track has a pullup, so a track no
// one drives reads 1; routes are made visible by driving 0 from the source.
module tb_bidir_switch_box;

  import bidir_switch_box_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] cfg = '0;
  logic [11:0] oe  = '0;   // {left,right,top,bottom} bench driver enables
  logic [11:0] drv = '0;   // {left,right,top,bottom} bench driver values
  wire logic [2:0] left, right, top, bottom;
  logic        cfg_err;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_tb
    pullup (left[i]);
    pullup (right[i]);
    pullup (top[i]);
    pullup (bottom[i]);
    assign left[i]   = oe[9+i] ? drv[9+i] : 1'bz;
    assign right[i]  = oe[6+i] ? drv[6+i] : 1'bz;
    assign top[i]    = oe[3+i] ? drv[3+i] : 1'bz;
    assign bottom[i] = oe[i]   ? drv[i]   : 1'bz;
  end

  bidir_switch_box #(.W(3)) dut (
    .clk(clk), .rst(rst), .cfg(cfg),
    .left(left), .right(right), .top(top), .bottom(bottom),
    .cfg_err(cfg_err)
  );

  typedef struct {
    string       name;
    logic [35:0] cfg;
    logic [11:0] oe;
    logic [11:0] drv;
    logic [11:0] exp_ports;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [35:0] cb(side_pair_e sp, int unsigned t, logic dir);
    logic [35:0] one;
    one = 36'd1;
    return one << cfg_bit(sp, t, dir);
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"bt_t0_lo",   cb(SP_BT,0,DIR_XY), 12'b000_000_000_001, 12'h000, 12'b111_111_110_110, 1'b0};
    vecs[1]  = '{"bt_t0_hi",   cb(SP_BT,0,DIR_XY), 12'b000_000_000_001, 12'h001, 12'b111_111_111_111, 1'b0};
    vecs[2]  = '{"tb_t0_lo",   cb(SP_BT,0,DIR_YX), 12'b000_000_001_000, 12'h000, 12'b111_111_110_110, 1'b0};
    vecs[3]  = '{"tb_t0_hi",   cb(SP_BT,0,DIR_YX), 12'b000_000_001_000, 12'h008, 12'b111_111_111_111, 1'b0};
    vecs[4]  = '{"fanout_lo",  cb(SP_LR,0,DIR_XY) | cb(SP_LT,0,DIR_XY), 12'b001_000_000_000, 12'h000, 12'b110_110_110_111, 1'b0};
    vecs[5]  = '{"fanout_hi",  cb(SP_LR,0,DIR_XY) | cb(SP_LT,0,DIR_XY), 12'b001_000_000_000, 12'h200, 12'b111_111_111_111, 1'b0};
    vecs[6]  = '{"both_fwd",   cb(SP_BT,0,DIR_XY) | cb(SP_BT,0,DIR_YX), 12'b000_000_000_001, 12'h000, 12'b111_111_111_110, 1'b1};
    vecs[7]  = '{"both_rev",   cb(SP_BT,0,DIR_XY) | cb(SP_BT,0,DIR_YX), 12'b000_000_001_000, 12'h000, 12'b111_111_110_111, 1'b1};
    vecs[8]  = '{"contend_r0", cb(SP_LR,0,DIR_XY) | cb(SP_RT,0,DIR_YX), 12'b001_000_001_000, 12'h000, 12'b110_110_110_111, 1'b1};
    vecs[9]  = '{"rb_t2",      cb(SP_RB,2,DIR_XY), 12'b000_100_000_000, 12'h000, 12'b111_011_111_011, 1'b0};
    vecs[10] = '{"rl_t1",      cb(SP_LR,1,DIR_YX), 12'b000_010_000_000, 12'h000, 12'b101_101_111_111, 1'b0};
    vecs[11] = '{"contend_l1", cb(SP_LR,1,DIR_YX) | cb(SP_LT,1,DIR_YX), 12'b000_010_010_000, 12'h000, 12'b101_101_101_111, 1'b1};
    vecs[12] = '{"multi",      cb(SP_LB,1,DIR_XY) | cb(SP_RT,2,DIR_XY) | cb(SP_LR,0,DIR_YX),
                 12'b010_101_000_000, 12'h000, 12'b100_010_011_101, 1'b0};

    // Reset with an all-ones cfg on the input: nothing may be driven.
    rst = 1'b1; cfg = '1; oe = '0; drv = '0;
    step(); step();
    check("reset_ports", {left, right, top, bottom}, 12'hFFF);
    check("reset_err",   {11'd0, cfg_err}, 12'd0);

    rst = 1'b0; cfg = '0;
    step();

    // A new cfg must not route until the following edge.
    cfg = vecs[0].cfg; oe = vecs[0].oe; drv = vecs[0].drv;
    #1;
    check("pre_edge_ports", {left, right, top, bottom}, 12'b111_111_111_110);

    foreach (vecs[i]) begin
      cfg = vecs[i].cfg; oe = vecs[i].oe; drv = vecs[i].drv;
      step();
      check({vecs[i].name, "_ports"}, {left, right, top, bottom}, vecs[i].exp_ports);
      check({vecs[i].name, "_err"},   {11'd0, cfg_err}, {11'd0, vecs[i].exp_err});
    end

    // cfg_err follows the offending word by exactly one edge.
    cfg = cb(SP_BT,0,DIR_XY) | cb(SP_BT,0,DIR_YX); oe = '0; drv = '0;
    #1;
    check("err_pre_edge", {11'd0, cfg_err}, 12'd0);
    step();
    check("err_post_edge", {11'd0, cfg_err}, 12'd1);

    // Reset while a fan-out route is live, then recovery.
    cfg = vecs[4].cfg; oe = vecs[4].oe; drv = vecs[4].drv;
    step();
    check("live_ports", {left, right, top, bottom}, 12'b110_110_110_111);
    rst = 1'b1;
    step();
    check("midrst_ports", {left, right, top, bottom}, 12'b110_111_111_111);
    check("midrst_err",   {11'd0, cfg_err}, 12'd0);
    cfg = '1;
    step();
    check("midrst_hold_ports", {left, right, top, bottom}, 12'b110_111_111_111);
    check("midrst_hold_err",   {11'd0, cfg_err}, 12'd0);
    rst = 1'b0; cfg = vecs[4].cfg;
    step();
    check("recover_ports", {left, right, top, bottom}, 12'b110_110_110_111);
    check("recover_err",   {11'd0, cfg_err}, 12'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
